// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory responder.
package mem_pkg;

    localparam int WORD_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between an initiator and the memory responder.
interface mem_responder_if;
    import mem_pkg::*;

    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_array.sv
// mem_array: DEPTH x WORD_W RAM, synchronous write, combinational read.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory target with fixed response latency.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);

    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    state_t            state, state_nx;
    logic [3:0]        cnt;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] rd;
    logic              accept, err, we;

    assign accept = bus.req_valid && state == IDLE;
    assign err    = addr_q[1:0] != 2'b00 || {2'b00, addr_q[ADDR_W-1:2]} >= 32'(DEPTH);

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= accept ? 4'd0 : state == WAIT ? cnt + 4'd1 : cnt;
            if (accept) begin
                wr_q    <= bus.req_write;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
        end

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = accept ? WAIT : IDLE;
            WAIT:    state_nx = cnt == 4'(LATENCY - 1) ? RESP : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    // Errored requests complete like any other but never touch the array.
    assign we             = state == RESP && wr_q && !err;
    assign bus.req_ready  = state == IDLE;
    assign bus.resp_valid = state == RESP;
    assign bus.resp_err   = state == RESP && err;
    assign bus.resp_rdata = state == RESP && !wr_q && !err ? rd : '0;

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (addr_q[AW+1:2]),
        .wdata (wdata_q),
        .raddr (addr_q[AW+1:2]),
        .rdata (rd)
    );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: vector table, directed corner cases and random traffic vs a word-array model.
module tb_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if bus ();
    mem_responder_if b1 ();
    mem_responder_if b15 ();

    mem_responder #(.DEPTH(256), .LATENCY(2))  dut   (.clk(clk), .reset(reset), .bus(bus));
    mem_responder #(.DEPTH(256), .LATENCY(1))  dut1  (.clk(clk), .reset(reset), .bus(b1));
    mem_responder #(.DEPTH(256), .LATENCY(15)) dut15 (.clk(clk), .reset(reset), .bus(b15));

    logic        s_valid = 1'b0, s_write = 1'b0;
    logic [31:0] s_addr = '0, s_wdata = '0;
    assign b1.req_valid  = s_valid;
    assign b1.req_write  = s_write;
    assign b1.req_addr   = s_addr;
    assign b1.req_wdata  = s_wdata;
    assign b15.req_valid = s_valid;
    assign b15.req_write = s_write;
    assign b15.req_addr  = s_addr;
    assign b15.req_wdata = s_wdata;

    int total = 0;
    int bad = 0;
    logic [31:0] model [256];
    bit          known [256];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    // Expected outcome from the address rules alone: word index a/4 within 256 words, aligned.
    function automatic void ref_model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                      output logic [31:0] rd, output logic er, output bit sure);
        er = (a % 4 != 0) || (a / 4 >= 256);
        rd = '0;
        sure = 1'b1;
        if (!er && w) begin
            model[a[9:2]] = d;
            known[a[9:2]] = 1'b1;
        end else if (!er) begin
            rd = model[a[9:2]];
            sure = known[a[9:2]];
        end
    endfunction

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        chk("accept_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_write = ~w;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        lat = 0;
        rd = '0;
        er = 1'b0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            if (bus.resp_valid) begin
                lat = i;
                rd = bus.resp_rdata;
                er = bus.resp_err;
            end else begin
                chk("busy_ready", 32'(bus.req_ready), 32'd0);
                chk("idle_rdata", bus.resp_rdata, 32'd0);
                chk("idle_err", 32'(bus.resp_err), 32'd0);
            end
            @(negedge clk);
        end
        chk("pulse_once", 32'(bus.resp_valid), 32'd0);
        chk("ready_after", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic sweep(input logic w, output int l1, output int l15,
                         output logic [31:0] r1, output logic [31:0] r15);
        s_valid = 1'b1;
        s_write = w;
        s_addr  = 32'h4;
        s_wdata = 32'h0BAD_F00D;
        @(negedge clk);
        s_valid = 1'b0;
        l1 = 0;
        l15 = 0;
        r1 = '0;
        r15 = '0;
        for (int k = 1; k <= 40; k++) begin
            if (b1.resp_valid && l1 == 0) begin l1 = k; r1 = b1.resp_rdata; end
            if (b15.resp_valid && l15 == 0) begin l15 = k; r15 = b15.resp_rdata; end
            @(negedge clk);
        end
    endtask

    initial begin
        vec_t        tbl [10];
        logic [31:0] rd, erd, a, d;
        logic        er, eer, w;
        bit          sure;
        int          lat, l1, l15, busy, nresp;
        logic [31:0] r1, r15;
        int          acc [$];
        int          rsp [$];

        tbl[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2] = '{1'b1, 32'h12,  32'h12345678, 32'h0,        1'b1};
        tbl[3] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tbl[4] = '{1'b0, 32'h400, 32'h0,        32'h0,        1'b1};
        tbl[5] = '{1'b1, 32'h20,  32'h11112222, 32'h0,        1'b0};
        tbl[6] = '{1'b1, 32'h3FC, 32'hCAFEF00D, 32'h0,        1'b0};
        tbl[7] = '{1'b0, 32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[8] = '{1'b0, 32'h3FF, 32'h0,        32'h0,        1'b1};
        tbl[9] = '{1'b0, 32'h20,  32'h0,        32'h11112222, 1'b0};

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        chk("rst_err", 32'(bus.resp_err), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            txn(tbl[i].w, tbl[i].a, tbl[i].d, rd, er, lat);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd3);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
            chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].er));
            ref_model(tbl[i].w, tbl[i].a, tbl[i].d, erd, eer, sure);
        end

        // Two reads with req_valid held high: accepts must land 4 cycles apart.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h10;
        busy = 0;
        for (int j = 0; j < 14; j++) begin
            if (acc.size() == 2) bus.req_valid = 1'b0;
            if (bus.req_valid && bus.req_ready) acc.push_back(j);
            if (!bus.req_ready) busy++;
            if (bus.resp_valid) begin
                rsp.push_back(j);
                chk("b2b_rdata", bus.resp_rdata, 32'hDEADBEEF);
            end
            @(negedge clk);
        end
        chk("b2b_accepts", 32'(acc.size()), 32'd2);
        chk("b2b_resps", 32'(rsp.size()), 32'd2);
        chk("b2b_busy", 32'(busy), 32'd6);
        if (acc.size() == 2) chk("b2b_gap", 32'(acc[1] - acc[0]), 32'd4);
        if (acc.size() >= 1 && rsp.size() >= 1) chk("b2b_lat", 32'(rsp[0] - acc[0]), 32'd3);

        // Reset during WAIT abandons the write.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hAAAA5555;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("wait_busy", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("async_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        nresp = 0;
        for (int j = 0; j < 6; j++) begin
            if (bus.resp_valid) nresp++;
            @(negedge clk);
        end
        chk("abandon_resp", 32'(nresp), 32'd0);
        txn(1'b0, 32'h20, 32'h0, rd, er, lat);
        chk("abandon_rdata", rd, 32'h11112222);
        chk("abandon_lat", 32'(lat), 32'd3);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'($urandom_range(0, 2047));
                1:       a = 32'($urandom_range(256, 1023)) << 2;
                default: a = 32'($urandom_range(0, 15)) << 2;
            endcase
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            ref_model(w, a, d, erd, eer, sure);
            txn(w, a, d, rd, er, lat);
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd3);
            chk($sformatf("rnd%0d_err", i), 32'(er), 32'(eer));
            if (sure) chk($sformatf("rnd%0d_rdata", i), rd, erd);
        end

        sweep(1'b1, l1, l15, r1, r15);
        chk("lat1_wr", 32'(l1), 32'd2);
        chk("lat15_wr", 32'(l15), 32'd16);
        sweep(1'b0, l1, l15, r1, r15);
        chk("lat1_rd", 32'(l1), 32'd2);
        chk("lat15_rd", 32'(l15), 32'd16);
        chk("lat1_rdata", r1, 32'h0BADF00D);
        chk("lat15_rdata", r15, 32'h0BADF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
